// File: rtl/slice_demux_bp.sv
// Round-robin slice demultiplexer: realigns each chunk to byte 0 and feeds per-slice FWFT FIFOs.
// Optional per-slice chunk statistics when SLICE_DEMUX_BP_STATS_EN is defined.
module slice_demux_bp #(
  parameter int BUS_BYTES      = 32,
  parameter int MAX_NBR_SLICES = 4,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             flush,
  input  logic [9:0]                                       slices_per_line,
  input  logic [15:0]                                      chunk_size,
  input  logic [8*BUS_BYTES-1:0]                           in_data,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic                                             in_sof,
  output logic [8*BUS_BYTES*MAX_NBR_SLICES-1:0]            out_data,
  output logic [MAX_NBR_SLICES-1:0]                        out_valid,
  input  logic [MAX_NBR_SLICES-1:0]                        out_ready,
  output logic [MAX_NBR_SLICES-1:0]                        out_last,
  output logic [($clog2(BUS_BYTES)+1)*MAX_NBR_SLICES-1:0]  out_nbytes,
  output logic [MAX_NBR_SLICES-1:0]                        out_sof,
  output logic                                             cfg_err
`ifdef SLICE_DEMUX_BP_STATS_EN
  ,
  output logic [16*MAX_NBR_SLICES-1:0]                     chunk_cnt
`endif
);

  localparam int W   = 8 * BUS_BYTES;
  localparam int NBW = $clog2(BUS_BYTES) + 1;
  localparam int SW  = (MAX_NBR_SLICES > 1) ? $clog2(MAX_NBR_SLICES) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int EW  = W + NBW + 2;

  logic [2*W-1:0]            res_data;
  logic [NBW-1:0]            res_cnt;
  logic [15:0]               chunk_rem;
  logic [SW-1:0]             active;
  logic [MAX_NBR_SLICES-1:0] sof_pend;

  logic                      st_valid;
  logic [SW-1:0]             st_slice;
  logic [EW-1:0]             st_entry;

  logic [EW-1:0]             fmem   [MAX_NBR_SLICES][FIFO_DEPTH];
  logic [CW-1:0]             wr_ptr [MAX_NBR_SLICES];
  logic [CW-1:0]             rd_ptr [MAX_NBR_SLICES];
  logic [CW-1:0]             rsv    [MAX_NBR_SLICES];
  logic [EW-1:0]             ent    [MAX_NBR_SLICES];

  logic                      bad_cfg, accept, sof_acc, emit, is_last;
  logic [SW-1:0]             tgt, tgt_wrap;
  logic [15:0]               rem_eff;
  logic [NBW-1:0]            base_cnt, avail, need, n_emit;
  logic [2*W-1:0]            comb_data;
  logic [W-1:0]              word;
  logic [MAX_NBR_SLICES-1:0] full, push, pop, sof_eff, emit_oh;

  // FIFO read side and occupancy flags; rsv counts FIFO entries plus the word in the stage register
  always_comb begin
    out_data   = '0;
    out_valid  = '0;
    out_last   = '0;
    out_nbytes = '0;
    out_sof    = '0;
    for (int unsigned s = 0; s < MAX_NBR_SLICES; s++) begin
      ent[s]       = fmem[s][rd_ptr[s][PW-1:0]];
      out_valid[s] = (wr_ptr[s] != rd_ptr[s]);
      if (out_valid[s]) begin
        out_data[W*s +: W]       = ent[s][W-1:0];
        out_nbytes[NBW*s +: NBW] = ent[s][W +: NBW];
        out_last[s]              = ent[s][W+NBW];
        out_sof[s]               = ent[s][W+NBW+1];
      end
      pop[s]  = out_valid[s] & out_ready[s];
      push[s] = st_valid && (st_slice == SW'(s));
      full[s] = (rsv[s] == CW'(FIFO_DEPTH));
    end
  end

  always_comb begin
    bad_cfg  = (slices_per_line == '0) ||
               (32'(slices_per_line) > 32'(MAX_NBR_SLICES)) ||
               (32'(chunk_size) < 32'(BUS_BYTES));
    in_ready = rst_n & ~flush & (res_cnt < NBW'(BUS_BYTES)) & ~full[active] & ~cfg_err;
    accept   = in_valid & in_ready;
    sof_acc  = accept & in_sof;
    tgt      = sof_acc ? '0 : active;
    rem_eff  = (sof_acc || chunk_rem == '0) ? chunk_size : chunk_rem;
    base_cnt = sof_acc ? '0 : res_cnt;
    comb_data = sof_acc ? '0 : res_data;
    if (accept)
      comb_data = comb_data | ({{W{1'b0}}, in_data} << (8 * base_cnt));
    avail    = base_cnt + (accept ? NBW'(BUS_BYTES) : '0);
    is_last  = (rem_eff <= 16'(BUS_BYTES));
    need     = is_last ? rem_eff[NBW-1:0] : NBW'(BUS_BYTES);
    emit     = ~cfg_err & ~bad_cfg & ~full[tgt] & (avail >= need);
    n_emit   = emit ? need : '0;
    word     = '0;
    for (int unsigned b = 0; b < BUS_BYTES; b++)
      if (NBW'(b) < need) word[8*b +: 8] = comb_data[8*b +: 8];
    tgt_wrap = ((32'(tgt) + 32'd1 >= 32'(slices_per_line)) ||
                (32'(tgt) == 32'(MAX_NBR_SLICES - 1))) ? '0 : tgt + SW'(1);
    sof_eff  = sof_acc ? '1 : sof_pend;
    emit_oh  = {{(MAX_NBR_SLICES-1){1'b0}}, emit} << tgt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      res_data  <= '0;
      res_cnt   <= '0;
      chunk_rem <= '0;
      active    <= '0;
      sof_pend  <= '0;
      st_valid  <= 1'b0;
      st_slice  <= '0;
      st_entry  <= '0;
      cfg_err   <= 1'b0;
      for (int unsigned s = 0; s < MAX_NBR_SLICES; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        rsv[s]    <= '0;
      end
    end else begin
      cfg_err   <= bad_cfg;
      res_data  <= comb_data >> (8 * n_emit);
      res_cnt   <= avail - n_emit;
      chunk_rem <= emit ? (rem_eff - 16'(n_emit)) : (sof_acc ? chunk_size : chunk_rem);
      active    <= (emit && is_last) ? tgt_wrap : tgt;
      sof_pend  <= sof_eff & ~emit_oh;
      st_valid  <= emit;
      st_slice  <= tgt;
      st_entry  <= {sof_eff[tgt], is_last, need, word};
      for (int unsigned s = 0; s < MAX_NBR_SLICES; s++) begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + CW'(1);
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + CW'(1);
        rsv[s] <= rsv[s] + CW'(emit_oh[s]) - CW'(pop[s]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < MAX_NBR_SLICES; s++)
      if (push[s]) fmem[s][wr_ptr[s][PW-1:0]] <= st_entry;
  end

`ifdef SLICE_DEMUX_BP_STATS_EN
  logic [15:0] ccnt [MAX_NBR_SLICES];

  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < MAX_NBR_SLICES; s++) begin
      if (!rst_n || flush || sof_acc) ccnt[s] <= '0;
      else if (push[s] && st_entry[W+NBW]) ccnt[s] <= ccnt[s] + 16'd1;
    end
  end

  always_comb begin
    chunk_cnt = '0;
    for (int unsigned s = 0; s < MAX_NBR_SLICES; s++)
      chunk_cnt[16*s +: 16] = ccnt[s];
  end
`endif

endmodule

// File: tb/tb_slice_demux_bp.sv
// Directed bench for slice_demux_bp: per-slice scoreboard against a chunk-splitting model plus hand-computed checks.
`timescale 1ns/1ps
module tb_slice_demux_bp;
  localparam int BB  = 32;
  localparam int NS  = 4;
  localparam int FD  = 8;
  localparam int W   = 8 * BB;
  localparam int NBW = $clog2(BB) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [9:0]      slices_per_line;
  logic [15:0]     chunk_size;
  logic [W-1:0]    in_data;
  logic            in_valid, in_ready, in_sof;
  logic [W*NS-1:0] out_data;
  logic [NS-1:0]   out_valid, out_ready, out_last, out_sof;
  logic [NBW*NS-1:0] out_nbytes;
  logic            cfg_err;
`ifdef SLICE_DEMUX_BP_STATS_EN
  logic [16*NS-1:0] chunk_cnt;
`endif

  always #5 clk = ~clk;

  slice_demux_bp #(.BUS_BYTES(BB), .MAX_NBR_SLICES(NS), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .slices_per_line(slices_per_line), .chunk_size(chunk_size),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_nbytes(out_nbytes), .out_sof(out_sof),
`ifdef SLICE_DEMUX_BP_STATS_EN
    .chunk_cnt(chunk_cnt),
`endif
    .cfg_err(cfg_err)
  );

  typedef struct {
    int unsigned  slice;
    logic [W-1:0] data;
    int unsigned  nb;
    bit           last;
    bit           sof;
  } word_t;

  word_t       got[$];
  word_t       exp_q[$];
  word_t       mw;
  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  int unsigned stall_cnt = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && !flush) begin
      for (int s = 0; s < NS; s++) begin
        if (out_valid[s] && out_ready[s]) begin
          mw.slice = s;
          mw.data  = out_data[W*s +: W];
          mw.nb    = int'(out_nbytes[NBW*s +: NBW]);
          mw.last  = out_last[s];
          mw.sof   = out_sof[s];
          got.push_back(mw);
        end
      end
      if (in_valid && !in_ready) stall_cnt++;
    end
  end

  // Expected output of one frame: byte i = base+i, chunks dealt round-robin, pieces emitted once fully present
  task automatic model_frame(input int unsigned base, input int unsigned nwords,
                             input int unsigned csz, input int unsigned nsl);
    int unsigned total = nwords * BB;
    int unsigned k = 0;
    bit first[NS];
    word_t w;
    for (int s = 0; s < NS; s++) first[s] = 1'b1;
    for (int unsigned off = 0; off < total; off += csz) begin
      for (int unsigned p = 0; p < csz; p += BB) begin
        int unsigned len;
        len = (csz - p < BB) ? csz - p : BB;
        if (off + p + len <= total) begin
          w.slice = k % nsl;
          w.data  = '0;
          for (int unsigned b = 0; b < len; b++) w.data[8*b +: 8] = 8'(base + off + p + b);
          w.nb    = len;
          w.last  = (p + len == csz);
          w.sof   = first[w.slice];
          first[w.slice] = 1'b0;
          exp_q.push_back(w);
        end
      end
      k++;
    end
  endtask

  task automatic send_word(input logic [W-1:0] d, input bit sof);
    int unsigned waitc = 0;
    in_data = d; in_sof = sof; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waitc < 400) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) check("send_timeout", W'(in_ready), W'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_frame(input int unsigned base, input int unsigned nwords);
    logic [W-1:0] d;
    for (int unsigned i = 0; i < nwords; i++) begin
      for (int unsigned b = 0; b < BB; b++) d[8*b +: 8] = 8'(base + i*BB + b);
      send_word(d, i == 0);
    end
  endtask

  task automatic drain();
    int unsigned quiet = 0, cyc = 0;
    while (quiet < 6 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (out_valid == '0) quiet++; else quiet = 0;
    end
    if (quiet < 6) check("drain_timeout", W'(out_valid), W'(0));
    @(posedge clk); #1;
  endtask

  task automatic compare(input string tag);
    for (int s = 0; s < NS; s++) begin
      word_t g[$], e[$];
      foreach (got[i])   if (got[i].slice == s)   g.push_back(got[i]);
      foreach (exp_q[i]) if (exp_q[i].slice == s) e.push_back(exp_q[i]);
      check($sformatf("%s_s%0d_count", tag, s), W'(g.size()), W'(e.size()));
      for (int i = 0; i < g.size() && i < e.size(); i++) begin
        check($sformatf("%s_s%0d_w%0d_data", tag, s, i), g[i].data, e[i].data);
        check($sformatf("%s_s%0d_w%0d_nb", tag, s, i), W'(g[i].nb), W'(e[i].nb));
        check($sformatf("%s_s%0d_w%0d_last", tag, s, i), W'(g[i].last), W'(e[i].last));
        check($sformatf("%s_s%0d_w%0d_sof", tag, s, i), W'(g[i].sof), W'(e[i].sof));
      end
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned idx;
    in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = '1;
    slices_per_line = 10'd2; chunk_size = 16'd40;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready_low", W'(in_ready), W'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", W'(in_ready), W'(1));
    check("post_reset_out_valid", W'(out_valid), W'(0));
    check("post_reset_cfg_err", W'(cfg_err), W'(0));
    check("post_reset_out_data", out_data[W-1:0], W'(0));
    check("post_reset_out_nbytes", W'(out_nbytes), W'(0));
    @(posedge clk); #1;

    // two-slice realign: 40-byte chunks
    model_frame(0, 10, 40, 2);
    send_frame(0, 10);
    drain();
    idx = 0;
    foreach (got[i]) if (got[i].slice == 0) begin
      if (idx == 1) begin
        check("t1_s0_w1_nb", W'(got[i].nb), W'(8));
        check("t1_s0_w1_b0", W'(got[i].data[7:0]), W'(32));
        check("t1_s0_w1_last", W'(got[i].last), W'(1));
      end
      idx++;
    end
    idx = 0;
    foreach (got[i]) if (got[i].slice == 1) begin
      if (idx == 0) check("t1_s1_w0_b0", W'(got[i].data[7:0]), W'(40));
      if (idx == 1) begin
        check("t1_s1_w1_nb", W'(got[i].nb), W'(8));
        check("t1_s1_w1_b0", W'(got[i].data[7:0]), W'(72));
      end
      idx++;
    end
    compare("t1");

    // residual stall: 33-byte chunks, continuous input
    chunk_size = 16'd33;
    stall_cnt = 0;
    model_frame(16, 33, 33, 2);
    send_frame(16, 33);
    drain();
    check("t2_stall_seen", W'(stall_cnt > 0), W'(1));
    compare("t2");

    // backpressure on slice 1
    chunk_size = 16'd64;
    out_ready[1] = 1'b0;
    model_frame(64, 24, 64, 2);
    fork
      send_frame(64, 24);
      begin
        int unsigned c = 0;
        while (!(in_valid && !in_ready) && c < 300) begin
          @(negedge clk);
          c++;
        end
        check("t3_stall", W'(in_ready), W'(0));
        check("t3_s1_valid", W'(out_valid[1]), W'(1));
        repeat (10) @(negedge clk);
        check("t3_held", W'(in_ready), W'(0));
        @(posedge clk); #1 out_ready[1] = 1'b1;
      end
    join
    drain();
    compare("t3");

    // in_sof mid-chunk drops residual
    chunk_size = 16'd80;
    model_frame(128, 3, 80, 2);
    send_frame(128, 3);
    model_frame(32, 6, 80, 2);
    send_frame(32, 6);
    drain();
    compare("t4");

    // configuration errors
    slices_per_line = 10'd0;
    repeat (2) @(negedge clk);
    check("t5_cfg_err_set", W'(cfg_err), W'(1));
    check("t5_in_ready_low", W'(in_ready), W'(0));
    @(posedge clk); #1 slices_per_line = 10'd2;
    @(negedge clk);
    check("t5_cfg_err_hold", W'(cfg_err), W'(1));
    @(negedge clk);
    check("t5_cfg_err_clear", W'(cfg_err), W'(0));
    @(posedge clk); #1 chunk_size = 16'd16;
    repeat (2) @(negedge clk);
    check("t5_chunk_small", W'(cfg_err), W'(1));
    @(posedge clk); #1 chunk_size = 16'd64; slices_per_line = 10'd5;
    repeat (2) @(negedge clk);
    check("t5_slices_big", W'(cfg_err), W'(1));
    @(posedge clk); #1 slices_per_line = 10'd1;
    repeat (2) @(negedge clk);
    check("t5_single_ok", W'(cfg_err), W'(0));
    @(posedge clk); #1;
    model_frame(85, 6, 64, 1);
    send_frame(85, 6);
    drain();
    compare("t5");

    // stats and flush
    slices_per_line = 10'd3; chunk_size = 16'd32;
    repeat (2) @(posedge clk); #1;
    model_frame(200, 6, 32, 3);
    send_frame(200, 6);
    drain();
`ifdef SLICE_DEMUX_BP_STATS_EN
    check("t6_cnt_s0", W'(chunk_cnt[15:0]), W'(2));
    check("t6_cnt_s1", W'(chunk_cnt[31:16]), W'(2));
    check("t6_cnt_s2", W'(chunk_cnt[47:32]), W'(2));
    check("t6_cnt_s3", W'(chunk_cnt[63:48]), W'(0));
`endif
    compare("t6");
    out_ready = '0;
    send_frame(7, 4);
    repeat (4) @(negedge clk);
    check("t6_prefill_valid", W'(out_valid[0]), W'(1));
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("t6_flush_out_valid", W'(out_valid), W'(0));
    check("t6_flush_in_ready", W'(in_ready), W'(1));
    check("t6_flush_out_data", out_data[W-1:0], W'(0));
`ifdef SLICE_DEMUX_BP_STATS_EN
    check("t6_flush_cnt", W'(chunk_cnt), W'(0));
`endif
    repeat (3) @(negedge clk);
    check("t6_flush_stays_empty", W'(out_valid), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
